// File: rtl/rr_bus_mux.sv
// Purpose: registered N:1 bus mux; an internal round-robin or fixed-priority arbiter picks the source channel.
// Latency: 1 cycle from an input transfer to that beat appearing on out_data/out_sel.
// Backpressure: a held beat stalls while out_ready=0 and in_ready stays 0; out_ready reaches in_ready combinationally.
module rr_bus_mux #(
  parameter int WIDTH = 64,
  parameter int N     = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rr_en,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  // One output beat: source index plus its payload, kept together in a single register.
  typedef struct packed {
    logic [SELW-1:0]  sel;
    logic [WIDTH-1:0] data;
  } beat_t;

  logic [WIDTH-1:0] chan_data [N];
  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  rr_idx;
  logic [SELW-1:0]  fp_idx;
  logic [SELW-1:0]  grant;
  logic             rr_hit;
  logic             load_en;
  logic             any_req;
  logic             xfer;
  beat_t            beat_q;

  // Unflatten the channel bus so the payload mux indexes by channel number.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      chan_data[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // The output stage can take a new beat when empty or when its current beat leaves this cycle.
  assign load_en = !out_valid || out_ready;
  assign any_req = |in_valid;

  // Round-robin search: first requester at or after ptr, wrapping modulo N (N is a power of two,
  // so SELW-bit addition wraps for free).
  always_comb begin
    logic [SELW-1:0] cand;
    cand   = '0;
    rr_idx = '0;
    rr_hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = ptr + SELW'(k);
      if (!rr_hit && in_valid[cand]) begin
        rr_idx = cand;
        rr_hit = 1'b1;
      end
    end
  end

  // Fixed priority: lowest-index requester; scanning downward lets the lowest index win last.
  always_comb begin
    fp_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        fp_idx = SELW'(i);
      end
    end
  end

  // The mode bit is applied at every grant decision; ptr is left untouched on a mode change.
  assign grant = rr_en ? rr_idx : fp_idx;

  // A transfer happens whenever the stage can load and somebody is asking; never during reset.
  assign xfer = !reset && load_en && any_req;

  // Accept exactly the granted channel, and only on a cycle that actually transfers.
  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready[grant] = 1'b1;
    end
  end

  // Output register and rotation pointer; an idle load clears valid but keeps the last data/sel.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      beat_q    <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      out_valid <= xfer;
      if (xfer) begin
        beat_q.sel  <= grant;
        beat_q.data <= chan_data[grant];
        if (rr_en) begin
          ptr <= grant + SELW'(1);
        end
      end
    end
  end

  assign out_data = beat_q.data;
  assign out_sel  = beat_q.sel;

  a_ready_onehot: assert property (@(posedge clk) $onehot0(in_ready));

endmodule

// File: tb/tb_rr_bus_mux.sv
module tb_rr_bus_mux;
  localparam int N     = 4;
  localparam int WIDTH = 64;
  localparam int SELW  = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 rr_en;
  logic [N-1:0]         in_valid;
  logic [N*WIDTH-1:0]   in_data;
  logic [N-1:0]         in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_sel;
  logic                 out_ready;
  logic [WIDTH-1:0]     chan [N];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, expressed directly in terms of the behavioural rules.
  int               m_ptr   = 0;
  logic             m_valid = 1'b0;
  logic [WIDTH-1:0] m_data  = '0;
  int               m_sel   = 0;

  rr_bus_mux #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .rr_en     (rr_en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  always_comb begin
    in_data = '0;
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = chan[i];
  end

  // Which channel the rules say gets granted this cycle (-1 for none).
  function automatic int exp_grant();
    int idx;
    if (reset) return -1;
    if (m_valid && !out_ready) return -1;
    for (int k = 0; k < N; k++) begin
      idx = rr_en ? (m_ptr + k) % N : k;
      if (in_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_edge(input int g);
    if (reset) begin
      m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
    end else if (!m_valid || out_ready) begin
      if (g >= 0) begin
        m_valid = 1'b1; m_data = chan[g]; m_sel = g;
        if (rr_en) m_ptr = (g + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic settle(output int g);
    #1;
    g = exp_grant();
  endtask

  task automatic edge_adv(input int g);
    @(posedge clk);
    model_edge(g);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int g;
    reset = 1'b1; rr_en = 1'b1; out_ready = 1'b1; in_valid = '1;
    for (int i = 0; i < N; i++) chan[i] = 64'h1000 + 64'(i);
    for (int c = 0; c < 2; c++) begin
      settle(g);
      n_checks++;
      if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
      edge_adv(g);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (out_data !== 64'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_checks++;
    if (out_sel !== 2'd0) begin n_fail++; $display("FAIL reset_out_sel: got %0d want 0", out_sel); end
    reset = 1'b0;
    settle(g);
    n_checks++;
    if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b want 0001", in_ready); end
    edge_adv(g);
    n_checks++;
    if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 64'h1000) begin
      n_fail++; $display("FAIL reset_first_beat: got v=%b sel=%0d data=%h want v=1 sel=0 data=1000", out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_rr_rotation();
    int g;
    int e;
    reset = 1'b1; settle(g); edge_adv(g);
    reset = 1'b0; rr_en = 1'b1; out_ready = 1'b1; in_valid = '1;
    for (int i = 0; i < N; i++) chan[i] = 64'h1000 + 64'(i);
    for (int k = 0; k < 6; k++) begin
      e = k % N;
      settle(g);
      n_checks++;
      if (in_ready !== onehot(e)) begin n_fail++; $display("FAIL rr_in_ready[%0d]: got %b want %b", k, in_ready, onehot(e)); end
      edge_adv(g);
      n_checks++;
      if (out_sel !== 2'(e) || out_data !== 64'h1000 + 64'(e)) begin
        n_fail++; $display("FAIL rr_beat[%0d]: got sel=%0d data=%h want sel=%0d data=%h", k, out_sel, out_data, e, 64'h1000 + 64'(e));
      end
    end
  endtask

  task automatic test_fixed_priority();
    int g;
    rr_en = 1'b0; out_ready = 1'b1; in_valid = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      settle(g);
      n_checks++;
      if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL fp_in_ready[%0d]: got %b want 0010", k, in_ready); end
      edge_adv(g);
      n_checks++;
      if (out_sel !== 2'd1 || out_data !== 64'h1001) begin n_fail++; $display("FAIL fp_beat[%0d]: got sel=%0d data=%h want sel=1 data=1001", k, out_sel, out_data); end
    end
    in_valid = 4'b1000;
    for (int k = 0; k < 2; k++) begin
      settle(g);
      n_checks++;
      if (in_ready !== 4'b1000) begin n_fail++; $display("FAIL fp_ch3_ready[%0d]: got %b want 1000", k, in_ready); end
      edge_adv(g);
      n_checks++;
      if (out_sel !== 2'd3) begin n_fail++; $display("FAIL fp_ch3_sel[%0d]: got %0d want 3", k, out_sel); end
    end
  endtask

  task automatic test_backpressure();
    int g;
    rr_en = 1'b1; out_ready = 1'b1; in_valid = 4'b0100; chan[2] = 64'hA;
    settle(g); edge_adv(g);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 64'hA) begin n_fail++; $display("FAIL bp_load: got v=%b data=%h want v=1 data=a", out_valid, out_data); end
    chan[2] = 64'hB; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle(g);
      n_checks++;
      if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_stall_ready[%0d]: got %b want 0000", k, in_ready); end
      edge_adv(g);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 64'hA || out_sel !== 2'd2) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b sel=%0d data=%h want v=1 sel=2 data=a", k, out_valid, out_sel, out_data);
      end
    end
    out_ready = 1'b1;
    settle(g);
    n_checks++;
    if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_release_ready: got %b want 0100", in_ready); end
    edge_adv(g);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 64'hB) begin n_fail++; $display("FAIL bp_next_beat: got v=%b data=%h want v=1 data=b", out_valid, out_data); end
  endtask

  task automatic test_wrap();
    int g;
    reset = 1'b1; settle(g); edge_adv(g);
    reset = 1'b0; rr_en = 1'b1; out_ready = 1'b1; in_valid = 4'b0100;
    settle(g);
    n_checks++;
    if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL wrap_ch2_ready: got %b want 0100", in_ready); end
    edge_adv(g);
    in_valid = 4'b0011;
    settle(g);
    n_checks++;
    if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_ch0_ready: got %b want 0001", in_ready); end
    edge_adv(g);
    n_checks++;
    if (out_sel !== 2'd0) begin n_fail++; $display("FAIL wrap_ch0_sel: got %0d want 0", out_sel); end
    settle(g);
    n_checks++;
    if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL wrap_ch1_ready: got %b want 0010", in_ready); end
    edge_adv(g);
    n_checks++;
    if (out_sel !== 2'd1) begin n_fail++; $display("FAIL wrap_ch1_sel: got %0d want 1", out_sel); end
  endtask

  task automatic test_reset_mid_stall();
    int g;
    reset = 1'b0; rr_en = 1'b1; out_ready = 1'b1; in_valid = 4'b0010; chan[1] = 64'hDEAD;
    settle(g); edge_adv(g);
    n_checks++;
    if (out_valid !== 1'b1 || out_sel !== 2'd1) begin n_fail++; $display("FAIL rms_load: got v=%b sel=%0d want v=1 sel=1", out_valid, out_sel); end
    out_ready = 1'b0; in_valid = '1; reset = 1'b1;
    settle(g);
    n_checks++;
    if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL rms_reset_ready: got %b want 0000", in_ready); end
    edge_adv(g);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rms_valid_cleared: got %b want 0", out_valid); end
    reset = 1'b0; out_ready = 1'b1; in_valid = '0;
    for (int k = 0; k < 3; k++) begin
      settle(g); edge_adv(g);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rms_no_delivery[%0d]: got v=%b want 0", k, out_valid); end
    end
    in_valid = '1;
    settle(g);
    n_checks++;
    if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL rms_ptr_reset: got %b want 0001", in_ready); end
    edge_adv(g);
  endtask

  task automatic test_random();
    int g;
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) rr_en = ~rr_en;
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) chan[i] = {$urandom, $urandom};
      settle(g);
      n_checks++;
      if (in_ready !== onehot(g)) begin n_fail++; $display("FAIL rand_in_ready[%0d]: got %b want %b", c, in_ready, onehot(g)); end
      edge_adv(g);
      n_checks++;
      if (out_valid !== m_valid || out_sel !== 2'(m_sel) || out_data !== m_data) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: got v=%b sel=%0d data=%h want v=%b sel=%0d data=%h",
                 c, out_valid, out_sel, out_data, m_valid, m_sel, m_data);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rr_en = 1'b1; out_ready = 1'b1; in_valid = '0;
    for (int i = 0; i < N; i++) chan[i] = '0;
    test_reset();
    test_rr_rotation();
    test_fixed_priority();
    test_backpressure();
    test_wrap();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
